// File: rtl/exec_muldiv_alu.sv
// Execute stage: single-cycle ALU ops plus 16-iteration shift-add MUL / restoring DIV (done k+2 / k+17).
// start is ignored while busy; defining SIGNED_MULDIV_EN adds MULS/DIVS with an extra sign-fix cycle (k+18).
module exec_muldiv_alu #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    input  logic [WIDTH-1:0] data15,
    output logic             busy,
    output logic             done,
    output logic             write_en,
    output logic [1:0]       write_dst,
    output logic [WIDTH-1:0] result1,
    output logic [WIDTH-1:0] result2,
    output logic [WIDTH-1:0] result15,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_MUL  = 4'b0100;
    localparam logic [3:0] OP_DIV  = 4'b0101;
    localparam logic [3:0] OP_SWAP = 4'b0110;
    localparam logic [3:0] OP_ADDC = 4'b0111;
`ifdef SIGNED_MULDIV_EN
    localparam logic [3:0] OP_MULS = 4'b1100;
    localparam logic [3:0] OP_DIVS = 4'b1101;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXEC,
        S_MUL,
        S_DIV,
        S_SIGN,
        S_DONE
    } state_t;

    state_t r_state, w_state_nx;

    function automatic logic f_legal(input logic [3:0] o);
`ifdef SIGNED_MULDIV_EN
        return (o[3] == 1'b0) || (o == OP_MULS) || (o == OP_DIVS);
`else
        return o[3] == 1'b0;
`endif
    endfunction

    function automatic logic f_is_mul(input logic [3:0] o);
`ifdef SIGNED_MULDIV_EN
        return (o == OP_MUL) || (o == OP_MULS);
`else
        return o == OP_MUL;
`endif
    endfunction

    function automatic logic f_is_div(input logic [3:0] o);
`ifdef SIGNED_MULDIV_EN
        return (o == OP_DIV) || (o == OP_DIVS);
`else
        return o == OP_DIV;
`endif
    endfunction

    function automatic logic f_is_signed(input logic [3:0] o);
`ifdef SIGNED_MULDIV_EN
        return (o == OP_MULS) || (o == OP_DIVS);
`else
        return (o == 4'b1111) && (o != 4'b1111);
`endif
    endfunction

    logic [3:0]       r_op;
    logic [WIDTH-1:0] r_a, r_b;
    logic             r_cin;
    logic [WIDTH-1:0] r_hi, r_lo, r_m;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_res1, r_res2, r_res15;
    logic [1:0]       r_wdst;
    logic             r_dbz;

    logic             w_accept, w_last;
    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH-1:0] w_mul_hi, w_mul_lo;
    logic [WIDTH+1:0] w_div_trial;
    logic [WIDTH-1:0] w_div_hi, w_div_lo;
    logic [WIDTH:0]   w_addc;
    logic [WIDTH-1:0] w_alu1, w_alu2, w_alu15;
    logic [1:0]       w_alu_wd;
    logic             w_alu_dbz;

    assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_last   = (r_cnt == CW'(WIDTH - 1));

    // {hi,lo} is the running product with the multiplier shifting out of lo;
    // for divide, hi is the partial remainder and quotient bits shift into lo.
    always_comb begin
        w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_m} : '0);
        w_mul_hi    = w_mul_sum[WIDTH:1];
        w_mul_lo    = {w_mul_sum[0], r_lo[WIDTH-1:1]};
        w_div_trial = {1'b0, r_hi, r_lo[WIDTH-1]} - {2'b00, r_m};
        if (!w_div_trial[WIDTH+1]) begin
            w_div_hi = w_div_trial[WIDTH-1:0];
            w_div_lo = {r_lo[WIDTH-2:0], 1'b1};
        end else begin
            w_div_hi = {r_hi[WIDTH-2:0], r_lo[WIDTH-1]};
            w_div_lo = {r_lo[WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        w_addc    = {1'b0, r_a} + {1'b0, r_b} + {{WIDTH{1'b0}}, r_cin};
        w_alu1    = '0;
        w_alu2    = '0;
        w_alu15   = '0;
        w_alu_wd  = 2'b00;
        w_alu_dbz = 1'b0;
        case (r_op)
            OP_ADD:  w_alu1 = r_a + r_b;
            OP_SUB:  w_alu1 = r_a - r_b;
            OP_AND:  w_alu1 = r_a & r_b;
            OP_OR:   w_alu1 = r_a | r_b;
            OP_SWAP: begin
                w_alu1   = r_b;
                w_alu2   = r_a;
                w_alu_wd = 2'b01;
            end
            OP_ADDC: begin
                w_alu1   = w_addc[WIDTH-1:0];
                w_alu15  = {{(WIDTH-1){1'b0}}, w_addc[WIDTH]};
                w_alu_wd = 2'b10;
            end
`ifdef SIGNED_MULDIV_EN
            OP_DIV, OP_DIVS: begin
`else
            OP_DIV: begin
`endif
                // only reaches EXEC with a zero divisor
                w_alu1    = '1;
                w_alu15   = r_a;
                w_alu_wd  = 2'b10;
                w_alu_dbz = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef SIGNED_MULDIV_EN
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_sgn1, w_sgn15;
    logic               w_neg;

    always_comb begin
        w_neg      = r_a[WIDTH-1] ^ r_b[WIDTH-1];
        w_prod_fix = w_neg ? -{r_hi, r_lo} : {r_hi, r_lo};
        if (r_op == OP_MULS) begin
            w_sgn1  = w_prod_fix[WIDTH-1:0];
            w_sgn15 = w_prod_fix[2*WIDTH-1:WIDTH];
        end else begin
            w_sgn1  = w_neg ? -r_lo : r_lo;
            w_sgn15 = r_a[WIDTH-1] ? -r_hi : r_hi;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_accept) begin
                    if (f_is_mul(op))                             w_state_nx = S_MUL;
                    else if (f_is_div(op) && (data2 != '0))       w_state_nx = S_DIV;
                    else                                          w_state_nx = S_EXEC;
                end else begin
                    w_state_nx = S_IDLE;
                end
            end
            S_EXEC:       w_state_nx = S_DONE;
            S_MUL, S_DIV: if (w_last) w_state_nx = f_is_signed(r_op) ? S_SIGN : S_DONE;
            S_SIGN:       w_state_nx = S_DONE;
            default:      w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_cin   <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_m     <= '0;
            r_cnt   <= '0;
            r_res1  <= '0;
            r_res2  <= '0;
            r_res15 <= '0;
            r_wdst  <= 2'b00;
            r_dbz   <= 1'b0;
        end else if (w_accept) begin
            r_op  <= op;
            r_a   <= data1;
            r_b   <= data2;
            r_cin <= data15[0];
            r_hi  <= '0;
            r_cnt <= '0;
            r_dbz <= 1'b0;
            // signed ops iterate on magnitudes; the sign is restored afterwards
            r_lo  <= (f_is_signed(op) && data1[WIDTH-1]) ? -data1 : data1;
            r_m   <= (f_is_signed(op) && data2[WIDTH-1]) ? -data2 : data2;
        end else begin
            case (r_state)
                S_EXEC: begin
                    r_res1  <= w_alu1;
                    r_res2  <= w_alu2;
                    r_res15 <= w_alu15;
                    r_wdst  <= w_alu_wd;
                    r_dbz   <= w_alu_dbz;
                end
                S_MUL: begin
                    r_hi  <= w_mul_hi;
                    r_lo  <= w_mul_lo;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_res1  <= w_mul_lo;
                        r_res2  <= '0;
                        r_res15 <= w_mul_hi;
                        r_wdst  <= 2'b10;
                    end
                end
                S_DIV: begin
                    r_hi  <= w_div_hi;
                    r_lo  <= w_div_lo;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_res1  <= w_div_lo;
                        r_res2  <= '0;
                        r_res15 <= w_div_hi;
                        r_wdst  <= 2'b10;
                    end
                end
`ifdef SIGNED_MULDIV_EN
                S_SIGN: begin
                    r_res1  <= w_sgn1;
                    r_res15 <= w_sgn15;
                end
`endif
                default: ;
            endcase
        end
    end

    assign busy        = (r_state == S_EXEC) || (r_state == S_MUL) ||
                         (r_state == S_DIV)  || (r_state == S_SIGN);
    assign done        = (r_state == S_DONE);
    assign write_en    = done && f_legal(r_op);
    assign write_dst   = r_wdst;
    assign result1     = r_res1;
    assign result2     = r_res2;
    assign result15    = r_res15;
    assign div_by_zero = r_dbz;
endmodule

// File: doc/exec_muldiv_alu.md
Name: exec_muldiv_alu

Overview:
- Execute stage directly downstream of the 16x16 register file.
- Consumes the Data1/Data2/Data15 read values and produces WriteReg1/WriteReg2/WriteReg15 plus the 2-bit WriteDst code that the register file writes back.
- Single-cycle ALU ops plus 16-iteration shift-add multiply and restoring divide, under a start/done handshake.
- Wide results go to R15: product high word for multiply, remainder for divide.

Parameters:
WIDTH, 16, datapath width; must equal the register width (16). Iteration count = WIDTH.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
start  in  1  operation request; sampled only when busy=0
op  in  4  opcode, sampled with start
data1  in  16  operand A (register file Data1)
data2  in  16  operand B (register file Data2)
data15  in  16  R15 contents (register file Data15)
busy  out  1  operation in progress; start ignored
done  out  1  one-cycle pulse: results valid
write_en  out  1  pulses with done when a write-back is required
write_dst  out  2  00 = R[A] only, 01 = R[A] and R[B], 10 = R[A] and R15
result1  out  16  value for WriteReg1
result2  out  16  value for WriteReg2
result15  out  16  value for WriteReg15
div_by_zero  out  1  set with done on DIV by 0; held until next accepted start

Behaviour:
- Reset: state IDLE; busy, done, write_en, div_by_zero = 0; write_dst = 00; all result buses and internal registers = 0. Reset asserted mid-operation aborts immediately; no write_en is issued.
- States:
  - IDLE/DONE: busy=0; start accepted.
  - EXEC, MUL, DIV: busy=1; start ignored.
- Accepting start (edge E0): latch op, data1, data2, data15.
  - ALU ops go to EXEC.
  - MUL goes to MUL with count=0.
  - DIV goes to DIV with count=0, or to EXEC if divisor is 0.
- EXEC: one cycle, results registered, then DONE.
- MUL/DIV: one iteration per cycle, 16 cycles; on the 16th iteration go to DONE.
- DONE: done=1 for exactly one cycle. write_en=1 unless op is illegal. Go to IDLE, or accept a back-to-back start.
- Latency (start high in cycle k): ALU ops and div-by-zero done in k+2; MUL/DIV done in k+17.
- Results, write_dst and div_by_zero hold their values after done until the next accepted start.
- Opcodes:
  - 0000 ADD: result1 = A+B mod 2^16; write_dst 00.
  - 0001 SUB: result1 = A-B mod 2^16; write_dst 00.
  - 0010 AND; 0011 OR: write_dst 00.
  - 0100 MUL (unsigned): {result15, result1} = A*B, 32-bit product; write_dst 10.
  - 0101 DIV (unsigned): result1 = A/B, result15 = A%B; write_dst 10.
  - 0110 SWAP: result1 = B, result2 = A; write_dst 01.
  - 0111 ADDC: result1 = A+B+data15[0]; result15 = {15'b0, carry-out}; write_dst 10.
  - Any other op: illegal; EXEC path, results 0, write_dst 00, write_en=0, done still pulses.
- DIV by 0: result1 = 0xFFFF, result15 = A, div_by_zero = 1, write_dst 10, write_en = 1.
- result2 = 0 for all ops except SWAP; result15 = 0 where not defined above.

Optional Feature:
- Macro SIGNED_MULDIV_EN.
- Defined:
  - 1100 MULS: two's-complement, 32-bit product split result15/result1.
  - 1101 DIVS: quotient truncates toward zero; remainder takes the sign of the dividend.
  - Sign correction takes one extra cycle; done in k+18.
  - 0x8000 / 0xFFFF gives quotient 0x8000, remainder 0.
  - Divide by 0 behaves as for unsigned DIV.
- Undefined: 1100 and 1101 are illegal opcodes.

Test Plan:
- MUL A=0x0F00, B=0x0050 -> done in k+17, result15=0x0004, result1=0xB000, write_dst=10, write_en=1.
- DIV A=0xFF0F, B=0x0040 -> done in k+17, result1=0x03FC, result15=0x000F, div_by_zero=0.
- DIV A=0xCCCC, B=0x0000 -> done in k+2, result1=0xFFFF, result15=0xCCCC, div_by_zero=1.
- Back-to-back:
  - ADD A=0xFF0F, B=0xF0FF -> result1=0xF00E, write_dst=00.
  - start held high in DONE with SWAP A=0x6666, B=0x00FF -> result1=0x00FF, result2=0x6666, write_dst=01.
  - Pulse start during MUL busy -> ignored.
- rst low in cycle k+8 of a MUL -> all outputs 0 immediately, no done. After release, ADD 1+1 completes in 2 cycles with result1=0x0002.
- Illegal op 1111 -> done pulse in k+2, write_en=0. With SIGNED_MULDIV_EN, MULS 0xFF88 x 0x0002 -> result15=0xFFFF, result1=0xFF10, done k+18.
